// File: rtl/alarm_unit.sv
// alarm_unit: editable alarm time, alarm-instant detection, ring/flash output with dismiss and timeout.
// Build option ALARM_SNOOZE_EN adds snooze handling (SNOOZED state, snooze target and count).
module alarm_unit #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int FLASH_HZ       = 2,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [1:0] current_mode,
  input  logic [1:0] position,
  input  logic       add_pulse,
  input  logic       sub_pulse,
  input  logic       alarm_en,
  input  logic       dismiss,
  input  logic       snooze,
  input  logic [7:0] hours,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  output logic [7:0] alarm_hours,
  output logic [7:0] alarm_minutes,
  output logic [7:0] alarm_seconds,
  output logic       alarm_active,
  output logic       alarm_led,
  output logic [1:0] dbg_state
);

  localparam int HALF_RAW = CLK_HZ / (2 * FLASH_HZ);
  localparam int HALF_CYC = (HALF_RAW > 0) ? HALF_RAW : 1;
  localparam int FW       = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam int RW       = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
`ifdef ALARM_SNOOZE_EN
    S_SNOOZED = 2'd2,
`endif
    S_RINGING = 2'd1
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    al_h_q, al_h_d, al_m_q, al_m_d, al_s_q, al_s_d;
  logic [7:0]    seconds_q, seconds_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [FW-1:0] flash_q, flash_d;
  logic          led_q, led_d;
  logic          active_q, active_d;
  logic          tick, edit_evt, alarm_match;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [7:0]    tgt_h_q, tgt_h_d, tgt_m_q, tgt_m_d, tgt_s_q, tgt_s_d;
  logic [7:0]    snz_min_sum, snz_h, snz_m;
  logic          snz_match;
`else
  logic          unused_snooze;
  assign unused_snooze = snooze;
`endif

  function automatic logic [7:0] step_field(input logic [7:0] v, input logic [7:0] top,
                                            input logic up);
    if (up) return (v >= top) ? 8'd0 : v + 8'd1;
    return (v == 8'd0) ? top : v - 8'd1;
  endfunction

  // add/sub/dismiss/snooze are single-cycle pulses; no handshake, each is acted on in the cycle it is high.
  assign tick        = (seconds != seconds_q);
  assign seconds_d   = seconds;
  assign edit_evt    = (current_mode == 2'b10) && (position != 2'b11) && (add_pulse ^ sub_pulse);
  assign alarm_match = (hours == al_h_q) && (minutes == al_m_q) && (seconds == al_s_q);

  always_comb begin
    al_h_d = al_h_q;
    al_m_d = al_m_q;
    al_s_d = al_s_q;
    if (edit_evt) begin
      case (position)
        2'b00:   al_h_d = step_field(al_h_q, 8'd23, add_pulse);
        2'b01:   al_m_d = step_field(al_m_q, 8'd59, add_pulse);
        default: al_s_d = step_field(al_s_q, 8'd59, add_pulse);
      endcase
    end
  end

`ifdef ALARM_SNOOZE_EN
  assign snz_min_sum = minutes + 8'(SNOOZE_MINUTES);
  assign snz_match   = (hours == tgt_h_q) && (minutes == tgt_m_q) && (seconds == tgt_s_q);

  always_comb begin
    snz_m = snz_min_sum;
    snz_h = hours;
    if (snz_min_sum >= 8'd60) begin
      snz_m = snz_min_sum - 8'd60;
      snz_h = (hours >= 8'd23) ? 8'd0 : hours + 8'd1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d = snz_cnt_q;
    tgt_h_d   = tgt_h_q;
    tgt_m_d   = tgt_m_q;
    tgt_s_d   = tgt_s_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tick && alarm_match) begin
          state_d = S_RINGING;
          ring_d  = '0;
`ifdef ALARM_SNOOZE_EN
          snz_cnt_d = '0;
`endif
        end
      end
      S_RINGING: begin
        if (dismiss) begin
          state_d = S_IDLE;
`ifdef ALARM_SNOOZE_EN
          snz_cnt_d = '0;
`endif
        end else if (tick && (ring_q == RW'(RING_SECONDS - 1))) begin
          state_d = S_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze && (snz_cnt_q < SW'(MAX_SNOOZES))) begin
          state_d   = S_SNOOZED;
          snz_cnt_d = snz_cnt_q + 1'b1;
          tgt_h_d   = snz_h;
          tgt_m_d   = snz_m;
          tgt_s_d   = seconds;
`endif
        end else if (tick) begin
          ring_d = ring_q + 1'b1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      S_SNOOZED: begin
        if (dismiss) begin
          state_d   = S_IDLE;
          snz_cnt_d = '0;
        end else if (tick && snz_match) begin
          state_d = S_RINGING;
          ring_d  = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Disarming or touching the alarm time always abandons the current alarm event.
    if (!alarm_en || edit_evt) begin
      state_d = S_IDLE;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_d = '0;
`endif
    end

    active_d = (state_d == S_RINGING);
    led_d    = 1'b0;
    flash_d  = '0;
    if (state_d == S_RINGING) begin
      if (state_q != S_RINGING) begin
        led_d = 1'b1;
      end else if (flash_q == FW'(HALF_CYC - 1)) begin
        led_d = ~led_q;
      end else begin
        led_d   = led_q;
        flash_d = flash_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q   <= S_IDLE;
      al_h_q    <= '0;
      al_m_q    <= '0;
      al_s_q    <= '0;
      seconds_q <= '0;
      ring_q    <= '0;
      flash_q   <= '0;
      led_q     <= 1'b0;
      active_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q <= '0;
      tgt_h_q   <= '0;
      tgt_m_q   <= '0;
      tgt_s_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      al_h_q    <= al_h_d;
      al_m_q    <= al_m_d;
      al_s_q    <= al_s_d;
      seconds_q <= seconds_d;
      ring_q    <= ring_d;
      flash_q   <= flash_d;
      led_q     <= led_d;
      active_q  <= active_d;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q <= snz_cnt_d;
      tgt_h_q   <= tgt_h_d;
      tgt_m_q   <= tgt_m_d;
      tgt_s_q   <= tgt_s_d;
`endif
    end
  end

  assign alarm_hours   = al_h_q;
  assign alarm_minutes = al_m_q;
  assign alarm_seconds = al_s_q;
  assign alarm_active  = active_q;
  assign alarm_led     = led_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
- Sits beside the counter_alu clock: consumes the live binary hours/minutes/seconds and the mode_select mode, and provides the design's set-alarm mode.
- Holds an editable alarm time and exposes it to the display mux in mode 2'b10.
- Detects the alarm instant and drives a ring output plus a flashing LED, with dismiss, snooze and timeout handling.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- FLASH_HZ, 2, alarm_led toggle rate while ringing; half-period = CLK_HZ/(2*FLASH_HZ) cycles.
- RING_SECONDS, 60, ringing auto-stops after this many seconds ticks.
- SNOOZE_MINUTES, 5, snooze re-arm delay.
- MAX_SNOOZES, 3, snoozes allowed per alarm event.

Ports:
- CLK100MHZ  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- current_mode  in  2  from mode_select; 2'b10 = set-alarm mode.
- position  in  2  field select: 00 hours, 01 minutes, 10 seconds, 11 none.
- add_pulse  in  1  debounced one-cycle increment pulse.
- sub_pulse  in  1  debounced one-cycle decrement pulse.
- alarm_en  in  1  arm switch (level).
- dismiss  in  1  debounced one-cycle pulse; stops ringing.
- snooze  in  1  debounced one-cycle pulse.
- hours  in  8  live time, binary 0-23.
- minutes  in  8  live time, binary 0-59.
- seconds  in  8  live time, binary 0-59.
- alarm_hours  out  8  stored alarm hours.
- alarm_minutes  out  8  stored alarm minutes.
- alarm_seconds  out  8  stored alarm seconds.
- alarm_active  out  1  high while ringing.
- alarm_led  out  1  flashes while ringing, else 0.

Behaviour:
Interface:
- One clock, CLK100MHZ.
- reset is synchronous and active-high.

Reset (all outputs registered):
- Alarm time = 00:00:00.
- State = IDLE; alarm_active = 0; alarm_led = 0.
- Snooze count = 0; flash counter = 0; seconds_q = 0.

Editing:
- Active only when current_mode == 2'b10 and position != 11.
- add_pulse increments the selected field; sub_pulse decrements it.
- Wrap-around: hours 23->0 and 0->23; minutes/seconds 59->0 and 0->59.
- Result is visible on alarm_* the cycle after the pulse.
- add_pulse and sub_pulse in the same cycle: no change.
- Any edit forces state to IDLE and clears the snooze count.

Tick detection:
- seconds_q is the registered copy of seconds.
- tick = (seconds != seconds_q).

State machine:
- IDLE -> RINGING: on tick when alarm_en = 1 and {hours, minutes, seconds} equals the alarm time. alarm_active rises on the edge after the tick cycle (latency 1).
- RINGING:
  - Ring counter clears on entry and increments per tick.
  - Reaching RING_SECONDS -> IDLE.
  - dismiss -> IDLE; clears snooze count.
  - snooze with count < MAX_SNOOZES -> SNOOZED. Target = live time + SNOOZE_MINUTES minutes (seconds unchanged), minutes wrap at 60 with carry into hours, hours wrap at 24. Count increments.
  - snooze with count == MAX_SNOOZES is ignored.
  - dismiss and snooze in the same cycle: dismiss wins.
- SNOOZED -> RINGING: on tick when live time equals the snooze target. dismiss -> IDLE.
- Any state: alarm_en = 0 -> IDLE next cycle; snooze count cleared.
- Re-trigger in IDLE requires a fresh tick-match, so no immediate re-ring after dismiss in the same second.

Outputs:
- alarm_active = (state == RINGING).
- alarm_led: toggles every half-period while RINGING, starting at 1 on entry. Forced to 0 and flash counter cleared in any other state.

Reset mid-ring: returns to the reset values on the next edge.

Optional Feature:
- ALARM_SNOOZE_EN defined: snooze input, SNOOZED state, snooze target and count logic are present as specified.
- ALARM_SNOOZE_EN undefined: snooze input is ignored and the SNOOZED state does not exist. RINGING exits only via dismiss, timeout, alarm_en = 0 or reset.

Test Plan:
1. Reset, then current_mode = 10, position = 00, 25 add_pulses -> alarm_hours = 1 (wraps at 24). One sub_pulse from 00 -> 23.
2. Set alarm 07:30:00, alarm_en = 1, live time steps 07:29:59 -> 07:30:00 -> alarm_active = 1 one cycle after the tick; alarm_led toggles every CLK_HZ/4 cycles (use a small CLK_HZ).
3. Ringing, no input for 60 ticks -> alarm_active = 0 after tick 60, alarm_led = 0.
4. Ringing at 23:58:10, snooze -> SNOOZED with target 00:03:10. Ticks to 00:03:10 -> ringing again. Fourth snooze attempt (after 3 used) -> ignored, still ringing.
5. Ringing, dismiss and snooze in the same cycle -> IDLE, snooze count 0. Next tick with time still matching -> no ring.
6. Ringing, alarm_en = 0 -> alarm_active = 0 next cycle. Ringing, reset pulse -> alarm_* = 00:00:00 and all outputs 0.
